ceespu_irq_ctrl: RTL and testbench
==================================

// Module: ceespu_irq_ctrl
// PURPOSE
//  Interrupt controller/scheduler for the ceespu front end.
//  - Latches edge-triggered requests and picks the highest-priority pending one.
//  - Waits for a safe point in the decode stage, then fires a one-cycle take pulse.
//  - The pulse drives decode did_interrupt, fetch redirect to O_vector and the pipeline flush.
//  - Captures the return PC for the handler.
// PARAMETERS
//  NUM_IRQ        4        number of request lines, 1..8
//  VECTOR_BASE    14'h0004 word address of the vector for irq 0
//  VECTOR_STRIDE  4        word distance between consecutive vectors
// PORTS
//  I_clk             in   1        clock
//  I_rst             in   1        synchronous reset, active-high
//  I_irq             in   NUM_IRQ  request lines, synchronous to I_clk; rising edge = request
//  I_int_enabled     in   1        decode interrupts_enabled
//  I_stall           in   1        pipeline stall (decode not advancing)
//  I_imm_pending     in   1        decode holds a valid seti upper half (imm prefix not yet consumed)
//  I_branch_inflight in   1        branch in execute; redirect not yet resolved
//  I_PC              in   14       PC of instruction currently in decode = return address
//  O_take            out  1        one-cycle take pulse -> did_interrupt, fetch redirect, flush
//  O_vector          out  14       handler word address, valid while O_take=1
//  O_epc             out  14       return PC captured at take, held until next take
//  O_irq_id          out  3        id of the taken irq, held until next take
//  O_pending         out  NUM_IRQ  pending request bits
// BEHAVIOUR
//  Reset (I_rst=1 at posedge):
//  - State -> IDLE.
//  - O_take, O_vector, O_epc, O_irq_id, O_pending, irq_prev all -> 0.
//  - irq_prev resets to 0, so a line already high when reset releases counts as one edge.
//  - Reset overrides everything, including a FIRE in progress: O_take=0 from the next cycle.
//  Edge capture:
//  - pending[k] is set at a posedge when I_irq[k]=1 and irq_prev[k]=0.
//  - No counting: extra edges while pending[k] is already set are lost.
//  - If a set and a clear of pending[k] land on the same edge, the set wins.
//  Priority: lowest index wins, fixed, no rotation.
//  safe = |pending & I_int_enabled & !I_stall & !I_imm_pending & !I_branch_inflight
//  FSM (state encoding is free):
//  - IDLE: go to ARM when |pending.
//  - ARM:
//    - If safe at a posedge: go to FIRE and, on that edge, register
//      O_take=1, O_vector=VECTOR_BASE+id*VECTOR_STRIDE (mod 2^14), O_irq_id=id, O_epc=I_PC.
//      Clear pending[id] on the same edge.
//    - If pending drops to 0 (only possible via reset): go to IDLE.
//  - FIRE: O_take=1 for exactly this one cycle; next state is HOLD.
//  - HOLD: O_take=0. Stay until I_int_enabled=0, then go to IDLE, or straight to ARM if |pending.
//    - Purpose: the stale enable must not cause a second take before decode has cleared it.
//    - Nested interrupts become possible only after the handler re-enables (EINT / return).
//  Latency:
//  - Edge at cycle n -> pending visible at n+1.
//  - If safe is held, ARM is entered at n+2 and O_take is high at cycle n+3.
//  - Request lines sampled while in FIRE or HOLD still set pending bits.
//  - A lower-priority bit stays pending until it wins a later ARM.
//  Guards and holds:
//  - I_imm_pending blocks the take so a seti/consumer pair is never split.
//  - I_stall asserted in ARM simply holds the state (no partial take).
//  - O_vector is only meaningful while O_take=1; it holds its value otherwise.
// TESTING
//  1. Single irq: NUM_IRQ=4, enabled, no guards; pulse I_irq[2] at cycle 10, I_PC=14'h0123
//     -> O_take=1 only at cycle 13, O_vector=14'h000C, O_epc=14'h0123, O_irq_id=2, pending[2]=0.
//  2. Priority: edges on I_irq[3] and I_irq[1] in the same cycle -> first take id=1 (vector 0x0008).
//     Keep I_int_enabled=1 -> stays in HOLD, no second take.
//     Drop then re-raise I_int_enabled -> second take id=3 (vector 0x0010).
//  3. Guards: irq[0] pending with I_imm_pending=1 for 5 cycles, then I_branch_inflight=1 for 2,
//     then I_stall=1 for 1 -> no O_take during any guard; O_take on the first cycle after all clear.
//  4. Disabled: I_int_enabled=0, pulse I_irq[1] -> O_pending=4'b0010, no take.
//     Enable 20 cycles later -> take id=1 on the next edge, with O_epc = I_PC at that edge.
//  5. Reset mid-operation: assert I_rst in the FIRE cycle -> next cycle O_take=0, O_pending=0,
//     all outputs 0, FSM in IDLE. A line held high through reset produces exactly one new request.
//  6. Set/clear collision: new edge on I_irq[0] on the same edge as the irq 0 take
//     -> pending[0] stays 1 and is taken again after the HOLD exit.

Source files
------------

// File: rtl/ceespu_irq_ctrl.sv
// Interrupt scheduler for the ceespu front end: latches request edges, waits for a
// safe decode point, and issues a one-cycle take pulse with vector, return PC and id.
module ceespu_irq_ctrl #(
  parameter int unsigned NUM_IRQ       = 4,
  parameter logic [13:0] VECTOR_BASE   = 14'h0004,
  parameter int unsigned VECTOR_STRIDE = 4
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [NUM_IRQ-1:0] I_irq,
  input  logic               I_int_enabled,
  input  logic               I_stall,
  input  logic               I_imm_pending,
  input  logic               I_branch_inflight,
  input  logic [13:0]        I_PC,
  output logic               O_take,
  output logic [13:0]        O_vector,
  output logic [13:0]        O_epc,
  output logic [2:0]         O_irq_id,
  output logic [NUM_IRQ-1:0] O_pending
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [13:0]        STRIDE = 14'(VECTOR_STRIDE);
  localparam logic [NUM_IRQ-1:0] ONE    = NUM_IRQ'(1);

  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic               take_q, take_d;
  logic [13:0]        vector_q, vector_d;
  logic [13:0]        epc_q, epc_d;
  logic [2:0]         irq_id_q, irq_id_d;

  logic [NUM_IRQ-1:0] set_mask;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [NUM_IRQ-1:0] scan;
  logic [2:0]         win_id;
  logic               any_pending;
  logic               safe;
  logic               take_now;

  // Edge detection, guard evaluation and fixed lowest-index-wins arbitration.
  always_comb begin
    set_mask    = I_irq & ~irq_prev_q;
    irq_prev_d  = I_irq;
    any_pending = |pending_q;
    safe        = any_pending & I_int_enabled & ~I_stall & ~I_imm_pending
                  & ~I_branch_inflight;
    win_onehot  = pending_q & (~pending_q + ONE);
    win_id      = 3'd0;
    scan        = '0;
    for (int unsigned k = NUM_IRQ; k > 0; k--) begin
      scan = pending_q >> (k - 1);
      if (scan[0]) begin
        win_id = 3'(k - 1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    take_d   = 1'b0;
    take_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_pending) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!any_pending) begin
          state_d = ST_IDLE;
        end else if (safe) begin
          state_d  = ST_FIRE;
          take_d   = 1'b1;
          take_now = 1'b1;
        end
      end
      ST_FIRE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Leave only once decode has dropped the enable, so it cannot retrigger.
        if (!I_int_enabled) begin
          state_d = any_pending ? ST_ARM : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new edge on the same cycle as the clear of that bit keeps it pending.
  always_comb begin
    clr_mask  = take_now ? win_onehot : '0;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    vector_d  = vector_q;
    epc_d     = epc_q;
    irq_id_d  = irq_id_q;
    if (take_now) begin
      vector_d = VECTOR_BASE + 14'(win_id) * STRIDE;
      epc_d    = I_PC;
      irq_id_d = win_id;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      irq_prev_q <= '0;
      take_q     <= 1'b0;
      vector_q   <= '0;
      epc_q      <= '0;
      irq_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_prev_d;
      take_q     <= take_d;
      vector_q   <= vector_d;
      epc_q      <= epc_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign O_take    = take_q;
  assign O_vector  = vector_q;
  assign O_epc     = epc_q;
  assign O_irq_id  = irq_id_q;
  assign O_pending = pending_q;

endmodule

// File: tb/tb_ceespu_irq_ctrl.sv
// Directed bench for ceespu_irq_ctrl: a per-cycle vector table for reset, single
// request and guard blocking, plus hand sequences for priority, disable, reset and collision.
module tb_ceespu_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        en, stall, imm, br;
  logic [13:0] pc;
  logic        take;
  logic [13:0] vector, epc;
  logic [2:0]  irq_id;
  logic [3:0]  pending;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  ceespu_irq_ctrl #(
    .NUM_IRQ      (4),
    .VECTOR_BASE  (14'h0004),
    .VECTOR_STRIDE(4)
  ) dut (
    .I_clk            (clk),
    .I_rst            (rst),
    .I_irq            (irq),
    .I_int_enabled    (en),
    .I_stall          (stall),
    .I_imm_pending    (imm),
    .I_branch_inflight(br),
    .I_PC             (pc),
    .O_take           (take),
    .O_vector         (vector),
    .O_epc            (epc),
    .O_irq_id         (irq_id),
    .O_pending        (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        en, stall, imm, br;
    logic [13:0] pc;
    logic        take;
    logic [3:0]  pend;
    logic        full;
    logic [2:0]  id;
    logic [13:0] vec, epc;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic r, logic [3:0] i, logic e, logic s, logic m, logic b,
                              logic [13:0] p, logic t, logic [3:0] pd, logic f,
                              logic [2:0] id, logic [13:0] v, logic [13:0] ep);
    vec_t x;
    x.rst = r; x.irq = i; x.en = e; x.stall = s; x.imm = m; x.br = b; x.pc = p;
    x.take = t; x.pend = pd; x.full = f; x.id = id; x.vec = v; x.epc = ep;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] i, input logic e, input logic s,
                      input logic m, input logic b, input logic [13:0] p);
    rst = r; irq = i; en = e; stall = s; imm = m; br = b; pc = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_basic(input string tag, input logic t, input logic [3:0] pd);
    chk({tag, ".take"}, 32'(take), 32'(t));
    chk({tag, ".pending"}, 32'(pending), 32'(pd));
  endtask

  task automatic chk_full(input string tag, input logic t, input logic [3:0] pd,
                          input logic [2:0] id, input logic [13:0] v, input logic [13:0] ep);
    chk_basic(tag, t, pd);
    chk({tag, ".id"}, 32'(irq_id), 32'(id));
    chk({tag, ".vector"}, 32'(vector), 32'(v));
    chk({tag, ".epc"}, 32'(epc), 32'(ep));
  endtask

  initial begin
    rst = 1'b1; irq = '0; en = 1'b1; stall = 1'b0; imm = 1'b0; br = 1'b0; pc = '0;

    // Reset, single irq 2 at PC 0x123, then irq 0 held off by imm/branch/stall guards.
    tbl[0]  = mk(1, 4'b0000, 1, 0, 0, 0, 14'h000, 0, 4'b0000, 1, 0, 14'h000, 14'h000);
    tbl[1]  = mk(1, 4'b0000, 1, 0, 0, 0, 14'h000, 0, 4'b0000, 1, 0, 14'h000, 14'h000);
    tbl[2]  = mk(0, 4'b0000, 1, 0, 0, 0, 14'h000, 0, 4'b0000, 0, 0, 14'h000, 14'h000);
    tbl[3]  = mk(0, 4'b0100, 1, 0, 0, 0, 14'h123, 0, 4'b0100, 0, 0, 14'h000, 14'h000);
    tbl[4]  = mk(0, 4'b0000, 1, 0, 0, 0, 14'h123, 0, 4'b0100, 0, 0, 14'h000, 14'h000);
    tbl[5]  = mk(0, 4'b0000, 1, 0, 0, 0, 14'h123, 1, 4'b0000, 1, 2, 14'h00C, 14'h123);
    tbl[6]  = mk(0, 4'b0000, 1, 0, 0, 0, 14'h999, 0, 4'b0000, 1, 2, 14'h00C, 14'h123);
    tbl[7]  = mk(0, 4'b0000, 0, 0, 0, 0, 14'h000, 0, 4'b0000, 0, 0, 14'h000, 14'h000);
    tbl[8]  = mk(0, 4'b0000, 1, 0, 0, 0, 14'h000, 0, 4'b0000, 0, 0, 14'h000, 14'h000);
    tbl[9]  = mk(0, 4'b0001, 1, 0, 1, 0, 14'h200, 0, 4'b0001, 0, 0, 14'h000, 14'h000);
    tbl[10] = mk(0, 4'b0000, 1, 0, 1, 0, 14'h200, 0, 4'b0001, 0, 0, 14'h000, 14'h000);
    tbl[11] = mk(0, 4'b0000, 1, 0, 1, 0, 14'h200, 0, 4'b0001, 0, 0, 14'h000, 14'h000);
    tbl[12] = mk(0, 4'b0000, 1, 0, 1, 0, 14'h200, 0, 4'b0001, 0, 0, 14'h000, 14'h000);
    tbl[13] = mk(0, 4'b0000, 1, 0, 1, 0, 14'h200, 0, 4'b0001, 0, 0, 14'h000, 14'h000);
    tbl[14] = mk(0, 4'b0000, 1, 0, 0, 1, 14'h200, 0, 4'b0001, 0, 0, 14'h000, 14'h000);
    tbl[15] = mk(0, 4'b0000, 1, 0, 0, 1, 14'h200, 0, 4'b0001, 0, 0, 14'h000, 14'h000);
    tbl[16] = mk(0, 4'b0000, 1, 1, 0, 0, 14'h200, 0, 4'b0001, 0, 0, 14'h000, 14'h000);
    tbl[17] = mk(0, 4'b0000, 1, 0, 0, 0, 14'h211, 1, 4'b0000, 1, 0, 14'h004, 14'h211);
    tbl[18] = mk(0, 4'b0000, 1, 0, 0, 0, 14'h300, 0, 4'b0000, 1, 0, 14'h004, 14'h211);
    tbl[19] = mk(0, 4'b0000, 0, 0, 0, 0, 14'h000, 0, 4'b0000, 0, 0, 14'h000, 14'h000);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].irq, tbl[i].en, tbl[i].stall, tbl[i].imm, tbl[i].br, tbl[i].pc);
      if (tbl[i].full)
        chk_full($sformatf("tbl%0d", i), tbl[i].take, tbl[i].pend, tbl[i].id,
                 tbl[i].vec, tbl[i].epc);
      else
        chk_basic($sformatf("tbl%0d", i), tbl[i].take, tbl[i].pend);
    end

    // Priority: irq 3 and irq 1 together; 1 first, 3 only after enable toggles.
    step(0, 4'b1010, 1, 0, 0, 0, 14'h040); chk_basic("prio.edge", 0, 4'b1010);
    step(0, 4'b0000, 1, 0, 0, 0, 14'h040); chk_basic("prio.arm", 0, 4'b1010);
    step(0, 4'b0000, 1, 0, 0, 0, 14'h041);
    chk_full("prio.take1", 1, 4'b1000, 1, 14'h008, 14'h041);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b0000, 1, 0, 0, 0, 14'h050);
      chk_basic($sformatf("prio.hold%0d", i), 0, 4'b1000);
    end
    step(0, 4'b0000, 0, 0, 0, 0, 14'h060); chk_basic("prio.dis0", 0, 4'b1000);
    step(0, 4'b0000, 0, 0, 0, 0, 14'h060); chk_basic("prio.dis1", 0, 4'b1000);
    step(0, 4'b0000, 1, 0, 0, 0, 14'h061);
    chk_full("prio.take3", 1, 4'b0000, 3, 14'h010, 14'h061);
    step(0, 4'b0000, 1, 0, 0, 0, 14'h062); chk_basic("prio.after", 0, 4'b0000);
    step(0, 4'b0000, 0, 0, 0, 0, 14'h062); chk_basic("prio.idle", 0, 4'b0000);

    // Disabled: request waits 20 cycles, taken on the edge enable returns.
    step(0, 4'b0010, 0, 0, 0, 0, 14'h100); chk_basic("dis.edge", 0, 4'b0010);
    for (int i = 0; i < 20; i++) begin
      step(0, 4'b0000, 0, 0, 0, 0, 14'h100 + 14'(i));
      chk_basic($sformatf("dis.wait%0d", i), 0, 4'b0010);
    end
    step(0, 4'b0000, 1, 0, 0, 0, 14'h345);
    chk_full("dis.take", 1, 4'b0000, 1, 14'h008, 14'h345);
    step(0, 4'b0000, 1, 0, 0, 0, 14'h346); chk_basic("dis.after", 0, 4'b0000);
    step(0, 4'b0000, 0, 0, 0, 0, 14'h000); chk_basic("dis.idle", 0, 4'b0000);

    // Collision: new irq 0 edge on its own take edge keeps it pending.
    step(0, 4'b0001, 1, 0, 0, 0, 14'h050); chk_basic("col.edge", 0, 4'b0001);
    step(0, 4'b0000, 1, 0, 0, 0, 14'h050); chk_basic("col.arm", 0, 4'b0001);
    step(0, 4'b0001, 1, 0, 0, 0, 14'h055);
    chk_full("col.take1", 1, 4'b0001, 0, 14'h004, 14'h055);
    step(0, 4'b0000, 1, 0, 0, 0, 14'h056); chk_basic("col.hold", 0, 4'b0001);
    step(0, 4'b0000, 0, 0, 0, 0, 14'h057); chk_basic("col.dis", 0, 4'b0001);
    step(0, 4'b0000, 1, 0, 0, 0, 14'h058);
    chk_full("col.take2", 1, 4'b0000, 0, 14'h004, 14'h058);
    step(0, 4'b0000, 1, 0, 0, 0, 14'h059); chk_basic("col.after", 0, 4'b0000);
    step(0, 4'b0000, 0, 0, 0, 0, 14'h000); chk_basic("col.idle", 0, 4'b0000);

    // Reset in FIRE with irq 2 held high across reset: exactly one new request.
    step(0, 4'b0100, 1, 0, 0, 0, 14'h070); chk_basic("rst.edge", 0, 4'b0100);
    step(0, 4'b0100, 1, 0, 0, 0, 14'h070); chk_basic("rst.arm", 0, 4'b0100);
    step(0, 4'b0100, 1, 0, 0, 0, 14'h071);
    chk_full("rst.fire", 1, 4'b0000, 2, 14'h00C, 14'h071);
    step(1, 4'b0100, 1, 0, 0, 0, 14'h072);
    chk_full("rst.clear", 0, 4'b0000, 0, 14'h000, 14'h000);
    step(1, 4'b0100, 1, 0, 0, 0, 14'h072);
    chk_full("rst.hold", 0, 4'b0000, 0, 14'h000, 14'h000);
    step(0, 4'b0100, 1, 0, 0, 0, 14'h073); chk_basic("rst.reedge", 0, 4'b0100);
    step(0, 4'b0100, 1, 0, 0, 0, 14'h074); chk_basic("rst.rearm", 0, 4'b0100);
    step(0, 4'b0100, 1, 0, 0, 0, 14'h075);
    chk_full("rst.retake", 1, 4'b0000, 2, 14'h00C, 14'h075);
    step(0, 4'b0100, 1, 0, 0, 0, 14'h076); chk_basic("rst.after", 0, 4'b0000);
    step(0, 4'b0100, 0, 0, 0, 0, 14'h076); chk_basic("rst.dis", 0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b0100, 1, 0, 0, 0, 14'h077);
      chk_basic($sformatf("rst.quiet%0d", i), 0, 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
